// File: rtl/i2c_master_ctrl_pkg.sv
// Shared types and constants for the I2C master sequencer.
// State encoding and bus-level bit meanings.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_MNACK,
    ST_STOP,
    ST_DONE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_WR   = 1'b0;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_master_ctrl_sync_ff.sv
// Multi-flop synchronizer for the asynchronous SDA pad level.
// Resets to the released (high) bus level.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '1;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, addr+R/W, ACK,
// one data byte, ACK/NACK, STOP, paced by divider ticks.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       en_clk,
  input  logic       sample_h,
  input  logic       sample_l,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  localparam logic [2:0] MSB = 3'(BITS_PER_BYTE - 1);

  i2c_state_e state_q, state_d;

  logic       ph_q, ph_d;
  logic       load_q, load_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       ack_err_q, ack_err_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] abyte_q, abyte_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic sda_s;
  logic tick;
  logic last;
  logic active;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sda_in),
    .q    (sda_s)
  );

  assign tick   = sample_h | sample_l;
  assign last   = (idx_q == 3'd0);
  assign active = (state_q != ST_IDLE) &&
                  (state_q != ST_DONE);

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    load_d     = 1'b0;
    scl_d      = scl_q;
    sda_d      = sda_q;
    ack_err_d  = ack_err_q;
    idx_d      = idx_q;
    abyte_d    = abyte_q;
    wdata_d    = wdata_q;
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_START;
          abyte_d   = {cmd_addr, cmd_rw};
          wdata_d   = cmd_wdata;
          ack_err_d = 1'b0;
          ph_d      = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // SDA moves only on the clk after SCL has fallen
        if (load_q) begin
          sda_d = 1'b1;
          if (state_q == ST_ADDR) begin
            sda_d = abyte_q[idx_q];
          end else if (state_q == ST_WDATA) begin
            sda_d = wdata_q[idx_q];
          end else if (state_q == ST_STOP) begin
            sda_d = 1'b0;
          end
        end

        if (tick && !ph_q) begin
          ph_d = 1'b1;
          if (state_q == ST_START) begin
            sda_d = 1'b0;
          end else begin
            scl_d = 1'b1;
          end
        end else if (tick) begin
          ph_d   = 1'b0;
          load_d = 1'b1;
          scl_d  = 1'b0;
          unique case (state_q)
            ST_START: begin
              state_d = ST_ADDR;
              idx_d   = MSB;
            end
            ST_ADDR: begin
              if (last) state_d = ST_ADDR_ACK;
              else      idx_d   = idx_q - 3'd1;
            end
            ST_ADDR_ACK: begin
              idx_d = MSB;
              if (sda_s == I2C_NACK) begin
                ack_err_d = 1'b1;
                state_d   = ST_STOP;
              end else if (abyte_q[0] == I2C_WR) begin
                state_d = ST_WDATA;
              end else begin
                state_d = ST_RDATA;
              end
            end
            ST_WDATA: begin
              if (last) state_d = ST_WACK;
              else      idx_d   = idx_q - 3'd1;
            end
            ST_WACK: begin
              if (sda_s == I2C_NACK) ack_err_d = 1'b1;
              state_d = ST_STOP;
            end
            ST_RDATA: begin
              rd_shift_d = {rd_shift_q[6:0], sda_s};
              if (last) state_d = ST_MNACK;
              else      idx_d   = idx_q - 3'd1;
            end
            ST_MNACK: begin
              rd_data_d = rd_shift_q;
              state_d   = ST_STOP;
            end
            ST_STOP: begin
              load_d  = 1'b0;
              scl_d   = 1'b1;
              sda_d   = 1'b1;
              state_d = ST_DONE;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ph_q       <= 1'b0;
      load_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      ack_err_q  <= 1'b0;
      idx_q      <= '0;
      abyte_q    <= '0;
      wdata_q    <= '0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      load_q     <= load_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      ack_err_q  <= ack_err_d;
      idx_q      <= idx_d;
      abyte_q    <= abyte_d;
      wdata_q    <= wdata_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign en_clk    = active;
  assign busy      = active;
  assign done      = (state_q == ST_DONE);
  assign scl_out   = scl_q;
  assign sda_out   = sda_q;
  assign ack_err   = ack_err_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus monitor, slave model,
// directed vector table and randomized transactions.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       en_clk;
  logic       sample_h = 1'b0;
  logic       sample_l = 1'b0;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;

  logic slv_drv = 1'b1;
  assign sda_in = sda_out & slv_drv;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_rw   (cmd_rw),
    .cmd_wdata(cmd_wdata),
    .en_clk   (en_clk),
    .sample_h (sample_h),
    .sample_l (sample_l),
    .scl_out  (scl_out),
    .sda_out  (sda_out),
    .sda_in   (sda_in),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rd_data  (rd_data)
  );

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       ack1;
    logic       ack2;
    logic [7:0] rbyte;
    int         mode;
    int         poke;
    int         exp_ticks;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [7:0] model_rd = 8'h00;

  // slave configuration (driver-owned)
  logic       slv_rw = 1'b0;
  logic       slv_ack1 = 1'b0;
  logic       slv_ack2 = 1'b0;
  logic [7:0] slv_byte = 8'h00;

  // monitor-owned state
  int   starts = 0;
  int   stops = 0;
  int   done_cnt = 0;
  int   same_edge = 0;
  int   falls = 0;
  bit   act = 1'b0;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;
  logic p_ln = 1'b1;
  logic bits_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic slave_level(input int slot);
    if (slot == 8) return slv_ack1;
    if (slv_ack1) return 1'b1;
    if (slot >= 9 && slot <= 16 && slv_rw)
      return slv_byte[16-slot];
    if (slot == 17 && !slv_rw) return slv_ack2;
    return 1'b1;
  endfunction

  always @(negedge clk) begin : mon
    logic ln;
    ln = sda_out & slv_drv;
    if (done) done_cnt++;
    if (scl_out && p_scl && p_ln && !ln) begin
      starts++;
      falls = 0;
      act = 1'b1;
    end else if (scl_out && p_scl && !p_ln && ln) begin
      stops++;
      act = 1'b0;
      slv_drv = 1'b1;
    end
    if (!p_scl && scl_out) bits_q.push_back(ln);
    if (p_scl && !scl_out) begin
      if (p_sda !== sda_out) same_edge++;
      if (act) begin
        slv_drv = slave_level(falls);
        falls++;
      end
    end
    p_scl = scl_out;
    p_sda = sda_out;
    p_ln  = sda_out & slv_drv;
  end

  // Expected bus bits (one per SCL rise), ticks and results
  function automatic void model(input vec_t v,
                                input logic [7:0] prev,
                                output logic [31:0] eb,
                                output int nb,
                                output int et,
                                output logic ee,
                                output logic [7:0] er);
    logic [7:0] ab;
    logic [7:0] db;
    ab = {v.addr, v.rw};
    db = v.rw ? v.rbyte : v.wdata;
    eb = '0;
    nb = 0;
    for (int i = 7; i >= 0; i--) begin
      eb[nb] = ab[i];
      nb++;
    end
    eb[nb] = v.ack1;
    nb++;
    if (!v.ack1) begin
      for (int i = 7; i >= 0; i--) begin
        eb[nb] = db[i];
        nb++;
      end
      eb[nb] = v.rw ? 1'b1 : v.ack2;
      nb++;
    end
    eb[nb] = 1'b0;
    nb++;
    et = 2 + 2 * (nb - 1) + 2;
    ee = v.ack1 | (!v.rw & v.ack2);
    er = (v.rw && !v.ack1) ? v.rbyte : prev;
  endfunction

  task automatic tick(input bit h, input bit l);
    sample_h = h;
    sample_l = l;
    @(posedge clk);
    #1;
    sample_h = 1'b0;
    sample_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int mode, input int n);
    if (mode == 2) tick(1'b1, 1'b1);
    else if ((n + mode) % 2 == 0) tick(1'b1, 1'b0);
    else tick(1'b0, 1'b1);
  endtask

  task automatic start_cmd(input vec_t v);
    slv_rw   = v.rw;
    slv_ack1 = v.ack1;
    slv_ack2 = v.ack2;
    slv_byte = v.rbyte;
    chk("ready_idle", cmd_ready, 1);
    cmd_addr  = v.addr;
    cmd_rw    = v.rw;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_rw    = ~v.rw;
    cmd_wdata = ~v.wdata;
    chk("busy_en_rdy", {busy, en_clk, cmd_ready}, 3'b110);
  endtask

  task automatic run_txn(input vec_t v);
    logic [31:0] eb;
    logic [31:0] gb;
    int nb, et, base, s0, p0, d0, e0, n, gn;
    logic ee;
    logic [7:0] er;
    model(v, model_rd, eb, nb, et, ee, er);
    base = bits_q.size();
    s0 = starts;
    p0 = stops;
    d0 = done_cnt;
    e0 = same_edge;
    start_cmd(v);
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      if (v.poke > 0 && n == v.poke) begin
        chk("ready_busy", cmd_ready, 0);
        cmd_addr  = v.addr ^ 7'h7f;
        cmd_rw    = ~v.rw;
        cmd_wdata = v.wdata ^ 8'hff;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("busy_poke", busy, 1);
      end
      tick_n(v.mode, n);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("ticks", n, v.exp_ticks);
    chk("done_pulses", done_cnt - d0, 1);
    chk("ack_err", ack_err, v.exp_err);
    chk("rd_data", rd_data, v.exp_rd);
    chk("idle_out", {busy, en_clk, cmd_ready}, 3'b001);
    chk("bus_rel", {scl_out, sda_out}, 2'b11);
    chk("starts", starts - s0, 1);
    chk("stops", stops - p0, 1);
    chk("sda_scl_edge", same_edge - e0, 0);
    gn = bits_q.size() - base;
    gb = '0;
    for (int k = 0; k < gn && k < 32; k++)
      gb[k] = bits_q[base+k];
    chk("nbits", gn, nb);
    chk("bits", gb, eb);
    model_rd = er;
  endtask

  vec_t vt[6];

  initial begin
    vec_t v;
    logic [31:0] eb;
    int nb;

    vt[0] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00,
              0, 0, 40, 1'b0, 8'h00};
    vt[1] = '{7'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96,
              1, 0, 40, 1'b0, 8'h96};
    vt[2] = '{7'h11, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00,
              0, 0, 22, 1'b1, 8'h96};
    vt[3] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00,
              2, 0, 40, 1'b0, 8'h96};
    vt[4] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00,
              0, 15, 40, 1'b0, 8'h96};
    vt[5] = '{7'h22, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h00,
              1, 0, 40, 1'b1, 8'h96};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_out, 1);
    chk("rst_sda", sda_out, 1);
    chk("rst_en", en_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", ack_err, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) tick_n(0, k);
    chk("idle_tick", {scl_out, sda_out, busy, cmd_ready},
        4'b1101);

    for (int i = 0; i < 6; i++) run_txn(vt[i]);

    // reset during the WDATA bit-4 slot, SCL high
    v = '{7'h33, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00,
          0, 0, 40, 1'b0, 8'h00};
    start_cmd(v);
    for (int k = 0; k < 27; k++) tick_n(0, k);
    chk("pre_rst_scl", scl_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {scl_out, sda_out, en_clk, busy},
        4'b1100);
    chk("rst_async_rd", rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    v = '{7'h2D, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00,
          1, 0, 40, 1'b0, 8'h00};
    run_txn(v);

    for (int r = 0; r < 24; r++) begin
      v.addr  = 7'($urandom);
      v.rw    = 1'($urandom);
      v.wdata = 8'($urandom);
      v.ack1  = ($urandom_range(0, 3) == 0);
      v.ack2  = ($urandom_range(0, 3) == 0);
      v.rbyte = 8'($urandom);
      v.mode  = $urandom_range(0, 2);
      v.poke  = ($urandom_range(0, 3) == 0) ?
                $urandom_range(1, 18) : 0;
      model(v, model_rd, eb, nb, v.exp_ticks,
            v.exp_err, v.exp_rd);
      run_txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
